// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg: shared types and default geometry for the icache line fill unit
// Provides the fill FSM state type, default beat geometry and request/result structs.
package sargantana_icache_pkg;
   localparam int ICACHE_LINE_BYTES = 64;
   localparam int ICACHE_BEAT_BYTES = 16;
   localparam int ICACHE_N_BEATS    = ICACHE_LINE_BYTES / ICACHE_BEAT_BYTES;
   localparam int ICACHE_PADDR_W    = 40;
   localparam int ICACHE_WAY_W      = 2;

   typedef enum logic [1:0] {
      IFILL_IDLE,
      IFILL_REQ,
      IFILL_WAIT,
      IFILL_DONE
   } ifill_state_t;

   typedef struct packed {
      logic [ICACHE_PADDR_W-1:0] paddr;
      logic [ICACHE_WAY_W-1:0]   way;
   } fill_req_t;

   typedef struct packed {
      logic                           valid;
      logic [ICACHE_LINE_BYTES*8-1:0] data;
      logic [ICACHE_WAY_W-1:0]        way;
      logic [ICACHE_PADDR_W-1:0]      paddr;
   } fill_out_t;
endpackage

// File: rtl/icache_fill_beat_buf.sv
// icache_fill_beat_buf: per-beat line storage with arrival mask for out-of-order refill
// Ports: clk_i, rstn_i (sync active-low), clr_i clears the mask, wr_i/idx_i/data_i write one beat,
//        line_o is the assembled line (slot 0 in the low bits), full_o is set once every slot arrived.
module icache_fill_beat_buf #(
   parameter int N_BEATS    = 4,
   parameter int BEAT_W     = 128,
   parameter int BEAT_IDX_W = 2
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      clr_i,
   input  logic                      wr_i,
   input  logic [BEAT_IDX_W-1:0]     idx_i,
   input  logic [BEAT_W-1:0]         data_i,
   output logic [N_BEATS*BEAT_W-1:0] line_o,
   output logic                      full_o
);
   logic [N_BEATS-1:0]             mask_q;
   logic [N_BEATS-1:0][BEAT_W-1:0] data_q;

   // Duplicate beats rewrite the slot; setting an already-set mask bit is a no-op.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         mask_q <= '0;
         data_q <= '0;
      end else if (clr_i) begin
         mask_q <= '0;
      end else if (wr_i && int'(idx_i) < N_BEATS) begin
         mask_q[idx_i] <= 1'b1;
         data_q[idx_i] <= data_i;
      end
   end

   assign line_o = data_q;
   assign full_o = &mask_q;
endmodule

// File: rtl/icache_line_fill_unit.sv
// icache_line_fill_unit: icache refill engine, one miss -> line-aligned memory request -> assembled line
// Ports: clk_i/rstn_i (sync active-low); req_* miss request in, req_ready_o when idle; kill_i abandons;
//        mem_req_* line request out; mem_resp_* beats in (any order); inv_* invalidation snoop;
//        fill_* one-cycle line write pulse with data/way/paddr; busy_o when not idle.
// Optional: define ICACHE_FILL_CWF_EN to add cwf_valid_o/cwf_data_o critical-word forwarding.
module icache_line_fill_unit
   import sargantana_icache_pkg::*;
#(
   parameter  int LINE_BYTES = 64,
   parameter  int BEAT_BYTES = 16,
   parameter  int PADDR_W    = 40,
   parameter  int N_WAY      = 4,
   parameter  int IDX_W      = 6,
   localparam int N_BEATS    = LINE_BYTES / BEAT_BYTES,
   localparam int BEAT_IDX_W = N_BEATS > 1 ? $clog2(N_BEATS) : 1,
   localparam int WAY_W      = N_WAY > 1 ? $clog2(N_WAY) : 1,
   localparam int BEAT_W     = BEAT_BYTES * 8,
   localparam int LINE_W     = LINE_BYTES * 8
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [PADDR_W-1:0]    req_paddr_i,
   input  logic [WAY_W-1:0]      req_way_i,
   input  logic                  kill_i,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic [PADDR_W-1:0]    mem_req_paddr_o,
   input  logic                  mem_resp_valid_i,
   input  logic [BEAT_IDX_W-1:0] mem_resp_beat_i,
   input  logic [BEAT_W-1:0]     mem_resp_data_i,
   input  logic                  inv_valid_i,
   input  logic [IDX_W-1:0]      inv_idx_i,
   output logic                  fill_valid_o,
   output logic [LINE_W-1:0]     fill_data_o,
   output logic [WAY_W-1:0]      fill_way_o,
   output logic [PADDR_W-1:0]    fill_paddr_o,
   output logic                  busy_o
`ifdef ICACHE_FILL_CWF_EN
   ,
   output logic                  cwf_valid_o,
   output logic [BEAT_W-1:0]     cwf_data_o
`endif
);
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int BOFF_W = $clog2(BEAT_BYTES);

   ifill_state_t       state_q;
   logic [PADDR_W-1:0] paddr_q;
   logic [WAY_W-1:0]   way_q;
   logic               drop_q;
   logic               accept, beat_wr, line_full, inv_hit;

   assign accept  = state_q == IFILL_IDLE && req_valid_i;
   assign beat_wr = state_q == IFILL_WAIT && mem_resp_valid_i;
   assign inv_hit = inv_valid_i && state_q != IFILL_IDLE && inv_idx_i == paddr_q[OFF_W +: IDX_W];

   // A killed/invalidated fill still walks WAIT->DONE so the memory beats are fully consumed;
   // drop_q only suppresses the final write.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= IFILL_IDLE;
         paddr_q <= '0;
         way_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         case (state_q)
            IFILL_IDLE: if (req_valid_i) begin
               paddr_q <= req_paddr_i & ~(PADDR_W'(LINE_BYTES - 1));
               way_q   <= req_way_i;
               drop_q  <= 1'b0;
               state_q <= IFILL_REQ;
            end
            IFILL_REQ: begin
               if (inv_hit || (kill_i && mem_req_ready_i)) drop_q <= 1'b1;
               if (mem_req_ready_i) state_q <= IFILL_WAIT;
               else if (kill_i) state_q <= IFILL_IDLE;
            end
            IFILL_WAIT: begin
               if (kill_i || inv_hit) drop_q <= 1'b1;
               if (line_full) state_q <= IFILL_DONE;
            end
            default: state_q <= IFILL_IDLE;
         endcase
      end
   end

   icache_fill_beat_buf #(
      .N_BEATS   (N_BEATS),
      .BEAT_W    (BEAT_W),
      .BEAT_IDX_W(BEAT_IDX_W)
   ) u_beat_buf (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .clr_i (accept),
      .wr_i  (beat_wr),
      .idx_i (mem_resp_beat_i),
      .data_i(mem_resp_data_i),
      .line_o(fill_data_o),
      .full_o(line_full)
   );

   assign req_ready_o     = state_q == IFILL_IDLE;
   assign busy_o          = state_q != IFILL_IDLE;
   assign mem_req_valid_o = state_q == IFILL_REQ;
   assign mem_req_paddr_o = paddr_q;
   assign fill_paddr_o    = paddr_q;
   assign fill_way_o      = way_q;
   // Same-cycle invalidation in DONE must still cancel the write.
   assign fill_valid_o    = state_q == IFILL_DONE && !drop_q && !inv_hit;

`ifdef ICACHE_FILL_CWF_EN
   logic [BEAT_IDX_W-1:0] cwf_beat_q;
   logic                  cwf_done_q;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cwf_beat_q <= '0;
         cwf_done_q <= 1'b0;
      end else if (accept) begin
         cwf_beat_q <= req_paddr_i[BOFF_W +: BEAT_IDX_W];
         cwf_done_q <= 1'b0;
      end else if (cwf_valid_o) begin
         cwf_done_q <= 1'b1;
      end
   end

   assign cwf_valid_o = beat_wr && !drop_q && !cwf_done_q && mem_resp_beat_i == cwf_beat_q;
   assign cwf_data_o  = cwf_valid_o ? mem_resp_data_i : '0;
`endif
endmodule

// File: tb/tb_icache_line_fill_unit.sv
// tb_icache_line_fill_unit: directed self-checking bench with a transaction-level fill model
module tb_icache_line_fill_unit;
   logic         clk = 1'b0;
   logic         rstn;
   logic         req_valid, kill, mem_req_ready, mem_resp_valid, inv_valid;
   logic [39:0]  req_paddr;
   logic [1:0]   req_way, mem_resp_beat;
   logic [127:0] mem_resp_data;
   logic [5:0]   inv_idx;
   logic         req_ready_o, mem_req_valid_o, fill_valid_o, busy_o;
   logic [39:0]  mem_req_paddr_o, fill_paddr_o;
   logic [511:0] fill_data_o;
   logic [1:0]   fill_way_o;
`ifdef ICACHE_FILL_CWF_EN
   logic         cwf_valid_o;
   logic [127:0] cwf_data_o;
`endif

   icache_line_fill_unit dut (
      .clk_i(clk), .rstn_i(rstn),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr), .req_way_i(req_way),
      .kill_i(kill),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready), .mem_req_paddr_o(mem_req_paddr_o),
      .mem_resp_valid_i(mem_resp_valid), .mem_resp_beat_i(mem_resp_beat), .mem_resp_data_i(mem_resp_data),
      .inv_valid_i(inv_valid), .inv_idx_i(inv_idx),
      .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o), .fill_way_o(fill_way_o),
      .fill_paddr_o(fill_paddr_o), .busy_o(busy_o)
`ifdef ICACHE_FILL_CWF_EN
      , .cwf_valid_o(cwf_valid_o), .cwf_data_o(cwf_data_o)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int exp_fill_at = -1, fill_cnt = 0, last_fill_cyc = -1, acc_cyc = 0, base_cnt;
   int exp_cwf_at = -1, cwf_cnt = 0;
   bit chk_en = 0;

   // Transaction-level model: what the line holds, which beats arrived, whether the fill is doomed.
   logic [127:0] slot [4];
   logic [3:0]   mdl_mask;
   logic [39:0]  mdl_pa;
   logic [1:0]   mdl_way, mdl_cwf_beat;
   logic [127:0] exp_cwf_data;
   bit           mdl_live = 0, mdl_drop = 0, mdl_cwf_seen = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      if (fill_valid_o === 1'b1) begin
         fill_cnt++;
         last_fill_cyc = cyc;
      end
      chk("fill_valid", fill_valid_o, exp_fill_at == cyc);
      if (exp_fill_at == cyc) begin
         chk("fill_data", fill_data_o, {slot[3], slot[2], slot[1], slot[0]});
         chk("fill_way", fill_way_o, mdl_way);
         chk("fill_paddr", fill_paddr_o, mdl_pa);
      end
`ifdef ICACHE_FILL_CWF_EN
      if (cwf_valid_o === 1'b1) cwf_cnt++;
      chk("cwf_valid", cwf_valid_o, exp_cwf_at == cyc);
      if (exp_cwf_at == cyc) chk("cwf_data", cwf_data_o, exp_cwf_data);
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [39:0] pa, input logic [1:0] w);
      req_valid = 1; req_paddr = pa; req_way = w;
      acc_cyc = cyc; mdl_pa = {pa[39:6], 6'b0}; mdl_way = w; mdl_cwf_beat = pa[5:4];
      mdl_mask = '0; mdl_drop = 0; mdl_cwf_seen = 0; exp_fill_at = -1; exp_cwf_at = -1;
      base_cnt = fill_cnt;
      tick();
      req_valid = 0;
   endtask

   task automatic handshake(input bit k);
      chk("mem_req_valid", mem_req_valid_o, 1'b1);
      chk("mem_req_paddr", mem_req_paddr_o, mdl_pa);
      chk("req_ready_busy", req_ready_o, 1'b0);
      mem_req_ready = 1; kill = k;
      if (k) mdl_drop = 1;
      mdl_live = 1;
      tick();
      mem_req_ready = 0; kill = 0;
   endtask

   task automatic beat(input int i, input logic [127:0] d);
      mem_resp_valid = 1; mem_resp_beat = i[1:0]; mem_resp_data = d;
      if (mdl_live) begin
         slot[i] = d;
         if (!mdl_drop && !mdl_cwf_seen && i[1:0] == mdl_cwf_beat) begin
            exp_cwf_at = cyc; exp_cwf_data = d; mdl_cwf_seen = 1;
         end
         mdl_mask[i] = 1'b1;
         // Line completes: one cycle to see the full line, then the write cycle.
         if (&mdl_mask) begin
            mdl_live = 0;
            if (!mdl_drop) exp_fill_at = cyc + 2;
         end
      end
      tick();
      mem_resp_valid = 0;
   endtask

   function automatic logic [127:0] dat(input int t, input int i);
      logic [31:0] w;
      w = 32'(t * 16 + i) ^ 32'hC0DE_0000;
      return {4{w}};
   endfunction

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic check_reset_outputs();
      chk("rst_req_ready", req_ready_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_mem_req_valid", mem_req_valid_o, 1'b0);
      chk("rst_mem_req_paddr", mem_req_paddr_o, 40'h0);
      chk("rst_fill_valid", fill_valid_o, 1'b0);
      chk("rst_fill_data", fill_data_o, 512'h0);
      chk("rst_fill_way", fill_way_o, 2'h0);
      chk("rst_fill_paddr", fill_paddr_o, 40'h0);
   endtask

   initial begin
      rstn = 0; req_valid = 0; req_paddr = '0; req_way = '0; kill = 0; mem_req_ready = 0;
      mem_resp_valid = 0; mem_resp_beat = '0; mem_resp_data = '0; inv_valid = 0; inv_idx = '0;
      for (int i = 0; i < 4; i++) slot[i] = '0;
      idle(2);
      check_reset_outputs();
      rstn = 1;
      chk_en = 1;
      tick();

      // In-order zero-wait fill.
      accept(40'h80_0000_1234, 2'd2);
      chk("t1_mem_req_paddr_lit", mem_req_paddr_o, 40'h80_0000_1200);
      handshake(0);
      for (int i = 0; i < 4; i++) beat(i, dat(1, i));
      idle(3);
      chk("t1_fill_count", fill_cnt, base_cnt + 1);
      chk("t1_latency_lit", last_fill_cyc - acc_cyc, 7);
      chk("t1_ready_back", req_ready_o, 1'b1);

      // Out-of-order with a duplicate that must win.
      accept(40'h12_3456_78C0, 2'd1);
      handshake(0);
      beat(3, 128'hAAAA_AAAA_0000_0003_AAAA_AAAA_0000_0003);
      idle(1);
      beat(1, 128'hBBBB_BBBB_0000_0001_BBBB_BBBB_0000_0001);
      beat(1, 128'hCCCC_CCCC_0000_0011_CCCC_CCCC_0000_0011);
      idle(2);
      beat(0, 128'hDDDD_DDDD_0000_0000_DDDD_DDDD_0000_0000);
      beat(2, 128'hEEEE_EEEE_0000_0002_EEEE_EEEE_0000_0002);
      idle(3);
      chk("t2_fill_count", fill_cnt, base_cnt + 1);
      chk("t2_slot1_lit", fill_data_o[255:128], 128'hCCCC_CCCC_0000_0011_CCCC_CCCC_0000_0011);
      chk("t2_way_lit", fill_way_o, 2'd1);

      // Kill in REQ without handshake: request withdrawn.
      accept(40'h55_0000_0100, 2'd3);
      chk("t3_req_valid", mem_req_valid_o, 1'b1);
      kill = 1;
      tick();
      kill = 0;
      chk("t3_req_dropped", mem_req_valid_o, 1'b0);
      chk("t3_ready", req_ready_o, 1'b1);
      chk("t3_busy", busy_o, 1'b0);
      idle(8);
      chk("t3_fill_count", fill_cnt, base_cnt);

      // Kill in WAIT after two beats: remaining beats absorbed, no fill.
      accept(40'h55_0000_0200, 2'd0);
      handshake(0);
      beat(0, dat(4, 0));
      beat(1, dat(4, 1));
      kill = 1; mdl_drop = 1;
      tick();
      kill = 0;
      beat(2, dat(4, 2));
      beat(3, dat(4, 3));
      chk("t4_still_busy", busy_o, 1'b1);
      idle(2);
      chk("t4_ready_back", req_ready_o, 1'b1);
      chk("t4_fill_count", fill_cnt, base_cnt);

      // Matching invalidation in DONE cancels the write.
      accept(40'h80_0000_1234, 2'd1);
      handshake(0);
      for (int i = 0; i < 4; i++) beat(i, dat(5, i));
      tick();
      inv_valid = 1; inv_idx = mdl_pa[11:6]; exp_fill_at = -1;
      chk("t5_busy_done", busy_o, 1'b1);
      tick();
      inv_valid = 0;
      idle(2);
      chk("t5_fill_count", fill_cnt, base_cnt);

      // Non-matching invalidation in DONE leaves the fill alone.
      accept(40'h80_0000_1234, 2'd3);
      handshake(0);
      for (int i = 0; i < 4; i++) beat(i, dat(6, i));
      tick();
      inv_valid = 1; inv_idx = mdl_pa[11:6] ^ 6'h01;
      tick();
      inv_valid = 0;
      idle(2);
      chk("t6_fill_count", fill_cnt, base_cnt + 1);

      // Matching invalidation during WAIT dooms the fill.
      accept(40'h33_0000_0A40, 2'd2);
      handshake(0);
      beat(0, dat(7, 0));
      inv_valid = 1; inv_idx = mdl_pa[11:6]; mdl_drop = 1;
      tick();
      inv_valid = 0;
      for (int i = 1; i < 4; i++) beat(i, dat(7, i));
      idle(3);
      chk("t7_fill_count", fill_cnt, base_cnt);

      // Reset mid-WAIT, then stray beats.
      accept(40'hAB_CDEF_0000, 2'd2);
      handshake(0);
      beat(0, dat(8, 0));
      beat(1, dat(8, 1));
      rstn = 0; mdl_live = 0; exp_fill_at = -1; exp_cwf_at = -1;
      for (int i = 0; i < 4; i++) slot[i] = '0;
      tick();
      rstn = 1;
      check_reset_outputs();
      beat(2, dat(8, 2));
      beat(3, dat(8, 3));
      idle(4);
      chk("t8_fill_count", fill_cnt, base_cnt);
      chk("t8_ready", req_ready_o, 1'b1);

`ifdef ICACHE_FILL_CWF_EN
      // Critical word is beat 3 (offset 0x34); arrival order 2,3,0,1.
      cwf_cnt = 0;
      accept(40'h80_0000_1234, 2'd0);
      handshake(0);
      beat(2, dat(9, 2));
      beat(3, dat(9, 3));
      beat(0, dat(9, 0));
      beat(1, dat(9, 1));
      idle(3);
      chk("t9_cwf_count", cwf_cnt, 1);
      chk("t9_fill_count", fill_cnt, base_cnt + 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
